// File: rtl/result_streamer.sv
// Drives one run of the parallel multiplier, then streams its n x n result
// in row-major order over a valid/ready port with row-end and last flags.
`timescale 1ns/1ps
module result_streamer #(
    parameter int n     = 10,
    parameter int n_len = $clog2(n)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             mul_start,
    input  logic             mul_done,
    output logic [n_len-1:0] z_i,
    output logic [n_len-1:0] z_j,
    input  logic [31:0]      z_out,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_row_end,
    output logic             out_last,
    output logic             busy
);

    localparam logic [n_len-1:0] LAST = n_len'(n - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_STREAM,
        S_FLUSH
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_guard;
    logic       w_load;
    logic       w_accept;
    logic       w_at_end;
    logic       w_row_end;

    assign w_accept  = out_valid && out_ready;
    assign w_load    = (r_state == S_STREAM) && (!out_valid || out_ready);
    assign w_row_end = (z_j == LAST);
    assign w_at_end  = (z_i == LAST) && w_row_end;
    assign busy      = (r_state != S_IDLE);

    always_comb begin
        w_next    = r_state;
        mul_start = 1'b0;
        case (r_state)
            S_IDLE:   if (start) w_next = S_LAUNCH;
            S_LAUNCH: begin
                mul_start = 1'b1;
                w_next    = S_WAIT;
            end
            // The guard masks a done flag left high by the previous run.
            S_WAIT:   if (r_guard == 2'd2 && mul_done) w_next = S_STREAM;
            S_STREAM: if (w_load && w_at_end) w_next = S_FLUSH;
            S_FLUSH:  if (w_accept) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_guard     <= 2'd0;
            z_i         <= '0;
            z_j         <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_row_end <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            r_state <= w_next;

            if (r_state == S_LAUNCH)
                r_guard <= 2'd0;
            else if (r_state == S_WAIT && r_guard != 2'd2)
                r_guard <= r_guard + 2'd1;

            if (w_load) begin
                out_data    <= z_out;
                out_valid   <= 1'b1;
                out_row_end <= w_row_end;
                out_last    <= w_at_end;
                if (w_at_end) begin
                    z_i <= '0;
                    z_j <= '0;
                end else if (w_row_end) begin
                    z_i <= z_i + 1'b1;
                    z_j <= '0;
                end else begin
                    z_j <= z_j + 1'b1;
                end
            end else if (r_state == S_FLUSH && w_accept) begin
                out_valid   <= 1'b0;
                out_row_end <= 1'b0;
                out_last    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer with n=4 and a behavioural multiplier.
`timescale 1ns/1ps
module tb_result_streamer;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mul_start;
    logic        mul_done = 1'b0;
    logic [1:0]  z_i, z_j;
    logic [31:0] z_out;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_row_end;
    logic        out_last;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int since    = 0;
    int n_ms     = 0;
    bit force_done = 1'b0;

    result_streamer #(.n(N), .n_len(2)) dut (
        .clk(clk), .rst(rst), .start(start), .mul_start(mul_start),
        .mul_done(mul_done), .z_i(z_i), .z_j(z_j), .z_out(z_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_row_end(out_row_end), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rval(input int i, input int j);
        return 32'hC0DE_0000 + 32'(i * 256 + j * 3 + 1);
    endfunction

    assign z_out = rval(int'(z_i), int'(z_j));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one edge; the multiplier raises done 10 edges after mul_start.
    task automatic tick();
        logic ms;
        ms = mul_start;
        @(posedge clk);
        #1;
        if (ms) begin
            since = 0;
            n_ms++;
        end else if (since < 1000) begin
            since++;
        end
        mul_done = force_done || (since >= 10);
    endtask

    task automatic chk_reset();
        chk("rst_mul_start", mul_start, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_row_end", out_row_end, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", out_data, 0);
        chk("rst_zi", z_i, 0);
        chk("rst_zj", z_j, 0);
    endtask

    // mode 0: ready always; 1: ready pattern 1,0,0,1; 2: stall 3 cycles on last word
    task automatic drain(input int mode, input int stop_at);
        int idx = 0, hold = 0, rows = 0, lasts = 0;
        logic [31:0] sd;
        logic sr, sl;
        logic [1:0] si, sj;
        bit stalled;
        for (int c = 0; c < 300 && idx < stop_at; c++) begin
            case (mode)
                1:       out_ready = (c % 4 == 0) || (c % 4 == 3);
                2:       out_ready = !(out_valid && out_last && hold < 3);
                default: out_ready = 1'b1;
            endcase
            stalled = out_valid && !out_ready;
            if (stalled) begin
                sd = out_data; sr = out_row_end; sl = out_last; si = z_i; sj = z_j;
                if (mode == 2) begin
                    chk("flush_last", out_last, 1);
                    chk("flush_busy", busy, 1);
                    hold++;
                end
            end
            if (out_valid && out_ready) begin
                chk("data", out_data, rval(idx / N, idx % N));
                chk("row_end", out_row_end, 32'(idx % N == N - 1));
                chk("last", out_last, 32'(idx == N * N - 1));
                rows += int'(out_row_end);
                lasts += int'(out_last);
                idx++;
            end
            tick();
            if (stalled) begin
                chk("stall_data", out_data, sd);
                chk("stall_row_end", out_row_end, sr);
                chk("stall_last", out_last, sl);
                chk("stall_addr", {z_i, z_j}, {si, sj});
            end
        end
        chk("word_count", idx, stop_at);
        if (stop_at == N * N) begin
            chk("row_end_count", rows, N);
            chk("last_count", lasts, 1);
            chk("busy_after", busy, 0);
            chk("valid_after", out_valid, 0);
        end
        if (mode == 2) chk("flush_hold", hold, 3);
        out_ready = 1'b1;
    endtask

    initial begin
        int first;
        // Reset state
        tick(); tick();
        chk_reset();
        rst = 1'b0;

        // Basic run, ready always high
        start = 1'b1; tick(); start = 1'b0;
        chk("launch_pulse", mul_start, 1);
        chk("launch_busy", busy, 1);
        tick();
        chk("launch_one_cycle", mul_start, 0);
        drain(0, N * N);

        // Stale done: guard delays STREAM entry
        force_done = 1'b1; tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("stale_launch", mul_start, 1);
        first = 0;
        for (int c = 1; c <= 20 && first == 0; c++) begin
            tick();
            if (out_valid) first = c;
        end
        chk("first_valid_edge", first, 5);
        force_done = 1'b0;
        drain(0, N * N);

        // Backpressure pattern
        start = 1'b1; tick(); start = 1'b0;
        drain(1, N * N);

        // Reset mid-stream after 7 accepted words
        start = 1'b1; tick(); start = 1'b0;
        drain(0, 7);
        chk("pending_before_rst", out_valid, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_reset();
        tick();
        chk("no_reemit", out_valid, 0);
        start = 1'b1; tick(); start = 1'b0;
        drain(0, N * N);

        // Start held high: back-to-back runs
        n_ms = 0;
        start = 1'b1; tick();
        drain(0, N * N);
        drain(0, N * N);
        start = 1'b0;
        chk("pulses_per_two_runs", n_ms, 2);
        tick(); tick();

        // Stall on the last word
        start = 1'b1; tick(); start = 1'b0;
        drain(2, N * N);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/result_streamer.md
RESULT_STREAMER -- requirements
Module: result_streamer

Interface
REQ-001 Parameter n, default 10: matrix dimension, n x n result.
REQ-002 Parameter n_len, default $clog2(n): width of row/column index.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port start  input  1  request one multiply-and-drain run; sampled only in IDLE.
REQ-006 Port mul_start  output  1  one-cycle start pulse to the parallel multiplier.
REQ-007 Port mul_done  input  1  multiplier all-tiles-done flag (level).
REQ-008 Port z_i  output  n_len  result row address to the multiplier.
REQ-009 Port z_j  output  n_len  result column address to the multiplier.
REQ-010 Port z_out  input  32  result word; combinationally valid for the current z_i/z_j in the same cycle.
REQ-011 Port out_data  output  32  streamed result word.
REQ-012 Port out_valid  output  1  out_data valid.
REQ-013 Port out_ready  input  1  downstream accepts when out_valid and out_ready are both high on a rising edge.
REQ-014 Port out_row_end  output  1  qualifies out_data as the last column (j = n-1) of a row.
REQ-015 Port out_last  output  1  qualifies out_data as element (n-1, n-1).
REQ-016 Port busy  output  1  high in any state other than IDLE.

Function
REQ-017 States: IDLE, LAUNCH, WAIT, STREAM, FLUSH.
REQ-018 IDLE: start=1 -> LAUNCH; start=0 -> remain; z_i=z_j=0.
REQ-019 LAUNCH: mul_start=1 for exactly this one cycle; next state WAIT unconditionally.
REQ-020 WAIT: a 2-bit guard counter, cleared on entry, saturates at 2; transition to STREAM only when guard=2 and mul_done=1, so a stale done from a previous run is ignored for 2 cycles.
REQ-021 STREAM: address pair (z_i, z_j) starts at (0,0); the output register loads when out_valid=0 or (out_valid=1 and out_ready=1).
REQ-022 On load: out_data<=z_out, out_valid<=1, out_row_end<=(z_j==n-1), out_last<=(z_i==n-1 and z_j==n-1); address advances in row-major order, z_j wrapping n-1->0 with z_i incrementing.
REQ-023 Throughput: one word per cycle while out_ready stays high; first out_valid occurs on the edge after entering STREAM.
REQ-024 When the (n-1, n-1) word loads, the state moves to FLUSH and the address returns to (0,0); no further loads occur.
REQ-025 FLUSH: holds out_data, out_valid and flags stable until accepted; on acceptance out_valid<=0, out_last<=0, out_row_end<=0, next state IDLE.
REQ-026 While out_valid=1 and out_ready=0, out_data, out_row_end, out_last and the address shall not change.
REQ-027 Exactly n*n words are emitted per run; out_row_end asserts n times; out_last asserts once.
REQ-028 start is ignored outside IDLE; start held high across FLUSH->IDLE launches a new run on the next cycle.
REQ-029 mul_done falling during STREAM or FLUSH is ignored.
REQ-030 The address never exceeds n-1 in either dimension.

Reset
REQ-031 rst=1 at an edge forces IDLE; mul_start, out_valid, out_row_end, out_last and busy go to 0; out_data goes to 0; z_i=z_j=0; the guard counter goes to 0.
REQ-032 Reset takes priority over all other inputs, including mid-STREAM with a word pending; the pending word is dropped and not re-emitted.

Verification
REQ-033 n=4, start pulse, mul_done rises 10 cycles after mul_start, out_ready=1 -> 16 consecutive words R[0][0]..R[3][3] in row-major order; out_row_end on words 4, 8, 12, 16; out_last on word 16 only; busy falls one cycle after word 16.
REQ-034 mul_done held at 1 before start -> no STREAM entry until guard=2; first out_valid no earlier than the 4th edge after mul_start.
REQ-035 out_ready toggled 1,0,0,1 repeatedly -> no dropped or duplicated words; out_data stable during every stall; sequence matches REQ-033.
REQ-036 rst asserted after the 7th accepted word -> next-edge outputs match REQ-031; a new start yields the full 16 words starting from R[0][0].
REQ-037 start held high continuously -> back-to-back runs; each run emits exactly 16 words with one mul_start pulse per run.
REQ-038 out_ready=0 on the last word -> FLUSH holds out_last=1 and the data until out_ready=1, then IDLE.
